// File: rtl/hamming_decoding_receiver_if.sv
// Serial-in / word-out handshake bundle for the (15,11) Hamming receiver.
interface hamming_decoding_receiver_if;
    logic        DEVICE_EN;
    logic        SER_IN;
    logic        SER_VALID;
    logic        SER_FIRST;
    logic        DATA_READY;
    logic [10:0] DATA_OUT;
    logic        DATA_VALID;
    logic        ERR_CORR;
    logic [3:0]  SYNDROME;
    logic        OVERRUN;
    logic        FRAME_ERR;
    logic [7:0]  ERR_COUNT;

    modport master (
        output DEVICE_EN, SER_IN, SER_VALID, SER_FIRST, DATA_READY,
        input  DATA_OUT, DATA_VALID, ERR_CORR, SYNDROME,
        input  OVERRUN, FRAME_ERR, ERR_COUNT
    );

    modport slave (
        input  DEVICE_EN, SER_IN, SER_VALID, SER_FIRST, DATA_READY,
        output DATA_OUT, DATA_VALID, ERR_CORR, SYNDROME,
        output OVERRUN, FRAME_ERR, ERR_COUNT
    );
endinterface

// File: rtl/hamming_decoding_receiver.sv
// Serial (15,11) Hamming receiver with single-error correction.
// Optional corrected-error counter enabled by ERR_COUNT_EN.
module hamming_decoding_receiver (
    input logic CLK,
    input logic REST,
    hamming_decoding_receiver_if.slave bus
);
    typedef enum logic {IDLE, RECV} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [14:1] word;
    logic        smp;
    logic        wr, clr, done, frame_nx;

    logic [15:1] cw;
    logic [3:0]  syn;
    logic [10:0] data;

    logic [10:0] out_q;
    logic [3:0]  syn_q;
    logic        corr_q, valid_q, ovr_q, frame_q;
    logic        load;

    assign smp = bus.SER_VALID & bus.DEVICE_EN;

    function automatic logic [3:0] dpos(input int i);
        return 4'(i < 1 ? 3 : (i < 4 ? i + 4 : i + 5));
    endfunction

    always_ff @(posedge CLK or negedge REST) begin
        if (!REST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wr       = 1'b0;
        clr      = 1'b0;
        done     = 1'b0;
        frame_nx = 1'b0;
        if (smp) begin
            unique case (state)
                IDLE: begin
                    if (bus.SER_FIRST) begin
                        state_nx = RECV;
                        cnt_nx   = 4'd1;
                        clr      = 1'b1;
                    end
                end
                RECV: begin
                    if (bus.SER_FIRST) begin
                        frame_nx = 1'b1;
                        cnt_nx   = 4'd1;
                        clr      = 1'b1;
                    end else if (cnt == 4'd14) begin
                        done     = 1'b1;
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else begin
                        wr     = 1'b1;
                        cnt_nx = cnt + 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge REST) begin
        if (!REST) begin
            word <= '0;
        end else if (clr) begin
            word <= {13'b0, bus.SER_IN};
        end else if (wr) begin
            word[cnt + 4'd1] <= bus.SER_IN;
        end
    end

    // The 15th bit is decoded straight off the line, never stored.
    assign cw = {bus.SER_IN, word};

    always_comb begin
        syn = '0;
        for (int i = 1; i <= 15; i++) begin
            if (cw[i]) syn = syn ^ 4'(i);
        end
        data = '0;
        for (int i = 0; i < 11; i++) begin
            data[i] = cw[dpos(i)] ^ (syn == dpos(i));
        end
    end

    assign load = done & (~valid_q | bus.DATA_READY);

    always_ff @(posedge CLK or negedge REST) begin
        if (!REST) begin
            out_q   <= '0;
            syn_q   <= '0;
            corr_q  <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            ovr_q   <= done & valid_q & ~bus.DATA_READY;
            frame_q <= frame_nx;
            if (load) begin
                out_q   <= data;
                syn_q   <= syn;
                corr_q  <= (syn != 4'd0);
                valid_q <= 1'b1;
            end else if (valid_q & bus.DATA_READY) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef ERR_COUNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge CLK or negedge REST) begin
        if (!REST) begin
            err_cnt <= '0;
        end else if (load && syn != 4'd0 && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign bus.ERR_COUNT = err_cnt;
`else
    assign bus.ERR_COUNT = 8'h00;
`endif

    assign bus.DATA_OUT   = out_q;
    assign bus.SYNDROME   = syn_q;
    assign bus.ERR_CORR   = corr_q;
    assign bus.DATA_VALID = valid_q;
    assign bus.OVERRUN    = ovr_q;
    assign bus.FRAME_ERR  = frame_q;
endmodule

// File: doc/hamming_decoding_receiver.md
# hamming_decoding_receiver

Serial-in (15,11) Hamming decoder sitting directly downstream of the encoding shift path. Collects one 15-bit codeword from the serial line, computes the 4-bit syndrome, corrects any single-bit error and presents the 11 data bits on a valid/ready output register. Reception and output are decoupled, so the next codeword can arrive while the previous word waits for the consumer.

## Interface
- No parameters; code geometry fixed at n=15, k=11, 4 parity bits.
- CLK  in  1  system clock; all state updates on rising edge
- REST  in  1  asynchronous, active-low reset
- DEVICE_EN  in  1  block enable; when low, SER_VALID is ignored and the receive FSM holds
- SER_IN  in  1  serial codeword bit
- SER_VALID  in  1  SER_IN carries a bit this cycle
- SER_FIRST  in  1  with SER_VALID: this bit is codeword position 1
- DATA_READY  in  1  consumer accepts DATA_OUT this cycle
- DATA_OUT  out  11  corrected data bits D[10:0]
- DATA_VALID  out  1  DATA_OUT holds an unconsumed word
- ERR_CORR  out  1  the held word had a nonzero syndrome and one bit was flipped
- SYNDROME  out  4  syndrome of the held word
- OVERRUN  out  1  one-cycle pulse: a complete codeword was dropped
- FRAME_ERR  out  1  one-cycle pulse: partial codeword aborted by SER_FIRST
- ERR_COUNT  out  8  corrected-error counter (only with ERR_COUNT_EN)

## Operation
- Bit order on the line: Hamming position 1 first, position 15 last. Parity at positions 1,2,4,8; D[0]..D[10] at positions 3,5,6,7,9,10,11,12,13,14,15.
- Sample = SER_VALID & DEVICE_EN.
- Receive FSM, two states, 4-bit bit counter CNT:
  - IDLE: sample with SER_FIRST -> store bit as position 1, CNT=1, go RECV. Sample without SER_FIRST ignored.
  - RECV: sample without SER_FIRST -> store at position CNT+1, CNT+1. Sample with SER_FIRST -> discard partial word, pulse FRAME_ERR, store bit as position 1, CNT=1, stay RECV.
  - Storing position 15 -> codeword complete, go IDLE, CNT=0.
- Decode on completion (combinational from the 14 stored bits plus the incoming 15th): SYNDROME = XOR of indices of all 1-bit positions; nonzero -> invert bit at position SYNDROME before extracting data. Parity-position errors leave data unchanged but still set ERR_CORR.
- Output register: loads DATA_OUT, SYNDROME, ERR_CORR and sets DATA_VALID on completion if empty or drained in the same cycle; otherwise keeps the old word and pulses OVERRUN.
- DATA_VALID & DATA_READY -> DATA_VALID cleared next edge; DATA_OUT/SYNDROME/ERR_CORR hold last values.
- DEVICE_EN low does not affect the output handshake.

## Timing
- Reset (REST low, async): FSM IDLE, CNT=0, DATA_OUT=0, DATA_VALID=0, ERR_CORR=0, SYNDROME=0, OVERRUN=0, FRAME_ERR=0, ERR_COUNT=0. Reset mid-word discards the partial codeword.
- Latency: 15th bit sampled at edge k -> DATA_VALID=1 and DATA_OUT valid after edge k.
- Minimum spacing: back-to-back codewords at one bit per cycle, 15 cycles per word, sustained with DATA_READY tied high.
- Completion with DATA_VALID=1 and DATA_READY=1 in the same cycle: new word loaded, DATA_VALID stays 1, no OVERRUN.
- Completion with DATA_VALID=1 and DATA_READY=0: OVERRUN high for exactly the cycle after edge k; held word unchanged.
- FRAME_ERR and OVERRUN are registered, high one cycle, never both from the same sample.
- Gaps (SER_VALID low) between bits of a word are allowed and do not abort it.

## Configuration
- ERR_COUNT_EN defined: ERR_COUNT increments by 1 on every word loaded with ERR_CORR=1, saturates at 8'hFF, cleared only by reset.
- ERR_COUNT_EN undefined: counter logic absent, ERR_COUNT driven constant 0.

## Test plan
- Reset, then all-ones codeword (15 ones, SER_FIRST on bit 1), DATA_READY=1 -> DATA_OUT=11'h7FF, SYNDROME=0, ERR_CORR=0, DATA_VALID one cycle after 15th bit.
- All-ones codeword with position 5 sent as 0 -> DATA_OUT=11'h7FF, SYNDROME=4'd5, ERR_CORR=1; ERR_COUNT=1 when ERR_COUNT_EN.
- All-zeros codeword with position 8 flipped -> DATA_OUT=0, SYNDROME=4'd8, ERR_CORR=1.
- Two back-to-back words, DATA_READY=0 -> first held, OVERRUN one-cycle pulse at second completion; raise DATA_READY -> DATA_VALID clears after one edge.
- SER_FIRST reasserted after 7 bits, then full all-ones word -> FRAME_ERR one pulse, DATA_OUT=11'h7FF, no OVERRUN.
- REST low after 9 bits, release, send all-zeros word -> no output from partial word; DATA_OUT=0, DATA_VALID=1 once.
